// File: rtl/main_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states, opcode/funct
// encodings and the ALU select codes understood by the datapath ALU.
package main_control_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StBranch,
        StJump
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnXor = 6'b100110;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluAnd  = 3'b001;
    localparam logic [2:0] AluOr   = 3'b010;
    localparam logic [2:0] AluXor  = 3'b011;
    localparam logic [2:0] AluSlt  = 3'b100;
    localparam logic [2:0] AluZero = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU select; flags funct codes the datapath cannot execute.
module alu_decoder
    import main_control_fsm_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_select,
    output logic       valid
);

    always_comb begin
        alu_select = AluAdd;
        valid      = 1'b1;
        case (funct)
            FnAdd:   alu_select = AluAdd;
            FnAnd:   alu_select = AluAnd;
            FnOr:    alu_select = AluOr;
            FnXor:   alu_select = AluXor;
            FnSlt:   alu_select = AluSlt;
            default: valid      = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode and per-class
// execute/writeback steps, with mem_ready stalls in the memory states.
module main_control_fsm
    import main_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_select,
    output logic       alu_c_in,
    output logic [1:0] pc_src,
    output logic       zero_ext,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [2:0] r_alu_select;
    logic       r_valid;

    alu_decoder u_alu_decoder (
        .funct      (funct),
        .alu_select (r_alu_select),
        .valid      (r_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw:             state_d = StMemAdr;
                    OpRType:                state_d = StRExec;
                    OpAddi, OpAndi, OpOri:  state_d = StIExec;
                    OpBeq, OpBne:           state_d = StBranch;
                    OpJ:                    state_d = StJump;
                    default:                state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StRExec:  state_d = r_valid ? StRWb : StFetch;
            StIExec:  state_d = StIWb;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_select = AluAdd;
        pc_src     = 2'b00;
        zero_ext   = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OpLw, OpSw, OpRType, OpAddi, OpAndi, OpOri, OpBeq, OpBne, OpJ: ;
                    default: illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: i_or_d = 1'b1;
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            StMemWr: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            StRExec: begin
                alu_src_a  = 1'b1;
                alu_select = r_alu_select;
                illegal    = ~r_valid;
            end
            StRWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OpAndi: begin
                        alu_select = AluAnd;
                        zero_ext   = 1'b1;
                    end
                    OpOri: begin
                        alu_select = AluOr;
                        zero_ext   = 1'b1;
                    end
                    default: alu_select = AluAdd;
                endcase
            end
            StIWb: reg_write = 1'b1;
            StBranch: begin
                // Equality test: xor result is zero exactly when the operands match.
                alu_src_a  = 1'b1;
                alu_select = AluXor;
                pc_src     = 2'b01;
                pc_en      = (opcode == OpBne) ? ~zero : zero;
            end
            StJump: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset forces FETCH, whose enables follow mem_ready; suppress them until release.
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign alu_c_in = 1'b0;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: per-cycle vector table plus reset and
// illegal-opcode sequences.
module tb_main_control_fsm;
    import main_control_fsm_pkg::*;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_select;
        logic       alu_c_in;
        logic [1:0] pc_src;
        logic       zero_ext;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       mr;
        state_e     st;
        ctl_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, alu_c_in, zero_ext, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_select;

    int n_tests = 0;
    int n_fail  = 0;

    main_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_select (alu_select),
        .alu_c_in   (alu_c_in),
        .pc_src     (pc_src),
        .zero_ext   (zero_ext),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input state_e est, input ctl_t exp);
        ctl_t   act;
        state_e ast;
        act = {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_select, alu_c_in, pc_src, zero_ext, illegal};
        ast = dut.state_q;
        n_tests++;
        if (act !== exp || ast !== est) begin
            n_fail++;
            $display("FAIL %s: state %s ctl 'h%05h, required state %s ctl 'h%05h",
                     name, ast.name(), act, est.name(), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input logic mr, input state_e st, input ctl_t exp);
        vec_t v;
        v.op  = op;
        v.fn  = fn;
        v.z   = z;
        v.mr  = mr;
        v.st  = st;
        v.exp = exp;
        return v;
    endfunction

    ctl_t k_fw, k_fg, k_dec, k_dec_ill, k_madr, k_mrd, k_mwb, k_mwr, k_slt, k_rill, k_rwb;
    ctl_t k_ori, k_andi, k_iwb, k_bt, k_bf, k_jmp;
    vec_t vecs[$];

    initial begin
        k_fw = '0;          k_fw.alu_src_b = 2'b01;
        k_fg = k_fw;        k_fg.pc_en = 1'b1;       k_fg.ir_write = 1'b1;
        k_dec = '0;         k_dec.alu_src_b = 2'b11;
        k_dec_ill = k_dec;  k_dec_ill.illegal = 1'b1;
        k_madr = '0;        k_madr.alu_src_a = 1'b1; k_madr.alu_src_b = 2'b10;
        k_mrd = '0;         k_mrd.i_or_d = 1'b1;
        k_mwb = '0;         k_mwb.mem_to_reg = 1'b1; k_mwb.reg_write = 1'b1;
        k_mwr = '0;         k_mwr.i_or_d = 1'b1;     k_mwr.mem_write = 1'b1;
        k_slt = '0;         k_slt.alu_src_a = 1'b1;  k_slt.alu_select = 3'b100;
        k_rill = '0;        k_rill.alu_src_a = 1'b1; k_rill.illegal = 1'b1;
        k_rwb = '0;         k_rwb.reg_dst = 1'b1;    k_rwb.reg_write = 1'b1;
        k_ori = k_madr;     k_ori.alu_select = 3'b010; k_ori.zero_ext = 1'b1;
        k_andi = k_madr;    k_andi.alu_select = 3'b001; k_andi.zero_ext = 1'b1;
        k_iwb = '0;         k_iwb.reg_write = 1'b1;
        k_bt = '0;          k_bt.alu_src_a = 1'b1;   k_bt.alu_select = 3'b011;
        k_bt.pc_src = 2'b01; k_bt.pc_en = 1'b1;
        k_bf = k_bt;        k_bf.pc_en = 1'b0;
        k_jmp = '0;         k_jmp.pc_src = 2'b10;    k_jmp.pc_en = 1'b1;

        // lw with one wait cycle in FETCH and in MEMRD
        vecs.push_back(mk(6'b100011, 6'h00, 0, 0, StFetch,  k_fw));
        vecs.push_back(mk(6'b100011, 6'h00, 0, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b100011, 6'h00, 0, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b100011, 6'h00, 0, 0, StMemAdr, k_madr));
        vecs.push_back(mk(6'b100011, 6'h00, 0, 0, StMemRd,  k_mrd));
        vecs.push_back(mk(6'b100011, 6'h00, 0, 1, StMemRd,  k_mrd));
        vecs.push_back(mk(6'b100011, 6'h00, 0, 0, StMemWb,  k_mwb));
        // sw with mem_write held through one wait cycle
        vecs.push_back(mk(6'b101011, 6'h00, 0, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b101011, 6'h00, 0, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b101011, 6'h00, 0, 0, StMemAdr, k_madr));
        vecs.push_back(mk(6'b101011, 6'h00, 0, 0, StMemWr,  k_mwr));
        vecs.push_back(mk(6'b101011, 6'h00, 0, 1, StMemWr,  k_mwr));
        // slt, then an unsupported funct that must not reach RWB
        vecs.push_back(mk(6'b000000, 6'b101010, 0, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b000000, 6'b101010, 0, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b000000, 6'b101010, 0, 0, StRExec,  k_slt));
        vecs.push_back(mk(6'b000000, 6'b101010, 0, 0, StRWb,    k_rwb));
        vecs.push_back(mk(6'b000000, 6'b000011, 0, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b000000, 6'b000011, 0, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b000000, 6'b000011, 0, 0, StRExec,  k_rill));
        vecs.push_back(mk(6'b000000, 6'b000011, 0, 0, StFetch,  k_fw));
        // ori, beq/bne with zero=1, j, andi
        vecs.push_back(mk(6'b001101, 6'h00, 0, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b001101, 6'h00, 0, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b001101, 6'h00, 0, 0, StIExec,  k_ori));
        vecs.push_back(mk(6'b001101, 6'h00, 0, 0, StIWb,    k_iwb));
        vecs.push_back(mk(6'b000100, 6'h00, 1, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b000100, 6'h00, 1, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b000100, 6'h00, 1, 0, StBranch, k_bt));
        vecs.push_back(mk(6'b000101, 6'h00, 1, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b000101, 6'h00, 1, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b000101, 6'h00, 1, 0, StBranch, k_bf));
        vecs.push_back(mk(6'b000010, 6'h00, 0, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b000010, 6'h00, 0, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b000010, 6'h00, 0, 0, StJump,   k_jmp));
        vecs.push_back(mk(6'b001100, 6'h00, 0, 1, StFetch,  k_fg));
        vecs.push_back(mk(6'b001100, 6'h00, 0, 0, StDecode, k_dec));
        vecs.push_back(mk(6'b001100, 6'h00, 0, 0, StIExec,  k_andi));
        vecs.push_back(mk(6'b001100, 6'h00, 0, 0, StIWb,    k_iwb));
        vecs.push_back(mk(6'b001100, 6'h00, 0, 0, StFetch,  k_fw));

        reset = 1'b1;
        opcode = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("reset_gates_enables", StFetch, k_fw);
        tick();
        tick();
        chk("reset_held_over_clocks", StFetch, k_fw);
        mem_ready = 1'b0;
        reset = 1'b0;

        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            funct = vecs[i].fn;
            zero = vecs[i].z;
            mem_ready = vecs[i].mr;
            #1;
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].exp);
            tick();
        end

        // Asynchronous reset while a store is mid-write
        opcode = 6'b101011;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        chk("sw_reach_memwr", StMemWr, k_mwr);
        reset = 1'b1;
        #1;
        chk("async_reset_memwr", StFetch, k_fw);
        mem_ready = 1'b1;
        #1;
        chk("reset_masks_fetch_en", StFetch, k_fw);
        tick();
        reset = 1'b0;
        #1;
        chk("first_fetch_after_reset", StFetch, k_fg);
        tick();
        chk("decode_after_reset", StDecode, k_dec);

        // Unsupported opcode: single illegal pulse, back to FETCH
        opcode = 6'b111111;
        mem_ready = 1'b0;
        #1;
        chk("illegal_opcode_decode", StDecode, k_dec_ill);
        tick();
        chk("illegal_opcode_return", StFetch, k_fw);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameters SHALL be: none; field widths fixed by MIPS32 (opcode 6, funct 6), ALU select 3.
REQ-002 clk  input  1  single system clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instr[31:26] from instruction register.
REQ-005 funct  input  6  instr[5:0] from instruction register.
REQ-006 zero  input  1  ALU zero flag, same cycle.
REQ-007 mem_ready  input  1  memory access complete this cycle.
REQ-008 pc_en  output  1  PC register load enable.
REQ-009 i_or_d  output  1  memory address mux: 0=PC, 1=ALUOut.
REQ-010 mem_write  output  1  memory write strobe.
REQ-011 ir_write  output  1  instruction register load.
REQ-012 reg_dst  output  1  write-reg mux: 0=rt, 1=rd.
REQ-013 mem_to_reg  output  1  write-data mux: 0=ALUOut, 1=MDR.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 alu_src_a  output  1  0=PC, 1=regA.
REQ-016 alu_src_b  output  2  00=regB, 01=constant 4, 10=extended imm, 11=imm<<2.
REQ-017 alu_select  output  3  ALU op: 000 add, 001 and, 010 or, 011 xor, 100 slt, 111 zero.
REQ-018 alu_c_in  output  1  ALU carry-in; SHALL be 0 always.
REQ-019 pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-020 zero_ext  output  1  1=zero-extend imm (andi/ori), 0=sign-extend.
REQ-021 illegal  output  1  one-cycle pulse on unsupported opcode/funct.

Function
REQ-022 Moore FSM; all outputs SHALL be a pure function of the state, except pc_en in BRANCH (uses zero); inactive outputs 0, alu_select default 000.
REQ-023 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP.
REQ-024 FETCH: i_or_d=0, ir_write=mem_ready, alu_src_a=0, alu_src_b=01, add, pc_src=00, pc_en=mem_ready; stays until mem_ready=1, then DECODE.
REQ-025 DECODE: alu_src_a=0, alu_src_b=11, add (branch target to ALUOut); next by opcode: 100011/101011->MEMADR, 000000->REXEC, 001000/001100/001101->IEXEC, 000100/000101->BRANCH, 000010->JUMP, other->FETCH with illegal=1.
REQ-026 MEMADR: alu_src_a=1, alu_src_b=10, add; lw->MEMRD, sw->MEMWR.
REQ-027 MEMRD: i_or_d=1; waits on mem_ready, then MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
REQ-028 MEMWR: i_or_d=1, mem_write=1 held until mem_ready=1, then FETCH.
REQ-029 REXEC: alu_src_a=1, alu_src_b=00, alu_select from funct: 100000 add, 100100 and, 100101 or, 100110 xor, 101010 slt -> RWB; other funct -> FETCH, illegal=1, no write.
REQ-030 RWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
REQ-031 IEXEC: alu_src_a=1, alu_src_b=10; addi add/zero_ext=0, andi and/zero_ext=1, ori or/zero_ext=1 -> IWB (rt, ALUOut) -> FETCH.
REQ-032 BRANCH: alu_src_a=1, alu_src_b=00, xor (equality via zero), pc_src=01; pc_en=zero for beq, ~zero for bne -> FETCH.
REQ-033 JUMP: pc_src=10, pc_en=1 -> FETCH.
REQ-034 Latency: lw 5 cycles, sw/R/I 4, beq/bne/j 3, each plus mem_ready wait cycles.

Reset
REQ-035 reset=1 SHALL force FETCH immediately (asynchronously), including mid-instruction; while asserted all write enables (pc_en, ir_write, mem_write, reg_write) and illegal SHALL be 0.
REQ-036 First FETCH SHALL begin on the first rising clk after reset deasserts.

Structure
REQ-037 Shared package SHALL hold the state enum, opcode/funct constants, and ALU select codes (also used by the ALU).
REQ-038 Funct-to-alu_select mapping SHALL be a sub-module alu_decoder; FSM in main_control_fsm.

Verification
REQ-039 lw (opcode 100011), mem_ready high 1 cycle late in FETCH and MEMRD -> state sequence FETCH,FETCH,DECODE,MEMADR,MEMRD,MEMRD,MEMWB; reg_write=1 only in MEMWB.
REQ-040 R-type funct 101010 -> REXEC alu_select=100, RWB reg_dst=1, reg_write=1; funct 000011 -> illegal pulse, no reg_write.
REQ-041 beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH; bne with zero=1 -> pc_en=0.
REQ-042 ori (001101) -> IEXEC alu_select=010, zero_ext=1; then IWB reg_write=1, reg_dst=0.
REQ-043 reset asserted in MEMWR with mem_write=1 -> mem_write=0 same cycle, state FETCH, no clock needed.
REQ-044 opcode 111111 in DECODE -> illegal=1 one cycle, return to FETCH, no write enables asserted.
